// File: rtl/seg7_pkg.sv
// Shared glyph definitions for the seven-segment scan driver.
// Glyphs are active-high, bit order {a,b,c,d,e,f,g}.
package seg7_pkg;

    typedef logic [6:0] glyph_t;

    localparam glyph_t SEG_BLANK = 7'b0000000;

    localparam glyph_t GLYPH_0 = 7'b1111110;
    localparam glyph_t GLYPH_1 = 7'b0110000;
    localparam glyph_t GLYPH_2 = 7'b1101101;
    localparam glyph_t GLYPH_3 = 7'b1111001;
    localparam glyph_t GLYPH_4 = 7'b0110011;
    localparam glyph_t GLYPH_5 = 7'b1011011;
    localparam glyph_t GLYPH_6 = 7'b1011111;
    localparam glyph_t GLYPH_7 = 7'b1110000;
    localparam glyph_t GLYPH_8 = 7'b1111111;
    localparam glyph_t GLYPH_9 = 7'b1111011;
    localparam glyph_t GLYPH_A = 7'b1110111;
    localparam glyph_t GLYPH_B = 7'b0011111;
    localparam glyph_t GLYPH_C = 7'b1001110;
    localparam glyph_t GLYPH_D = 7'b0111101;
    localparam glyph_t GLYPH_E = 7'b1001111;
    localparam glyph_t GLYPH_F = 7'b1000111;

    function automatic glyph_t hex_to_glyph(input logic [3:0] nibble);
        glyph_t glyph;
        case (nibble)
            4'h0:    glyph = GLYPH_0;
            4'h1:    glyph = GLYPH_1;
            4'h2:    glyph = GLYPH_2;
            4'h3:    glyph = GLYPH_3;
            4'h4:    glyph = GLYPH_4;
            4'h5:    glyph = GLYPH_5;
            4'h6:    glyph = GLYPH_6;
            4'h7:    glyph = GLYPH_7;
            4'h8:    glyph = GLYPH_8;
            4'h9:    glyph = GLYPH_9;
            4'hA:    glyph = GLYPH_A;
            4'hB:    glyph = GLYPH_B;
            4'hC:    glyph = GLYPH_C;
            4'hD:    glyph = GLYPH_D;
            4'hE:    glyph = GLYPH_E;
            4'hF:    glyph = GLYPH_F;
            default: glyph = SEG_BLANK;
        endcase
        return glyph;
    endfunction

    // Maps an active-high glyph onto pin levels for the chosen polarity.
    function automatic glyph_t apply_polarity(input glyph_t glyph, input logic active_low);
        glyph_t pins;
        if (active_low) begin
            pins = ~glyph;
        end else begin
            pins = glyph;
        end
        return pins;
    endfunction

endpackage

// File: rtl/hex_digit_decode.sv
// Combinational nibble to active-high seven-segment glyph decoder.
module hex_digit_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output glyph_t     glyph
);

    // Pure table lookup; polarity is handled by the caller.
    always_comb begin
        glyph = hex_to_glyph(nibble);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit seven-segment driver: shadow-latched hex value,
// refresh prescaler, digit scan with leading-zero blanking, registered pins.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 100000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      blank_lz,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_tick
);

    localparam int PRESC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PRESC_W-1:0]    PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam glyph_t                SEG_OFF    = SEG_ACTIVE_LOW ? 7'b1111111 : 7'b0000000;
    localparam logic                  DP_OFF     = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] AN_OFF     = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}}
                                                                 : {NUM_DIGITS{1'b0}};

    logic [4*NUM_DIGITS-1:0] shadow_value_r;
    logic [NUM_DIGITS-1:0]   shadow_dp_r;
    logic                    shadow_blank_r;
    logic [PRESC_W-1:0]      presc_r;
    logic [IDX_W-1:0]        idx_r;
    glyph_t                  seg_r;
    logic                    dp_r;
    logic [NUM_DIGITS-1:0]   an_r;
    logic                    frame_tick_r;

    logic [PRESC_W-1:0]      presc_next_s;
    logic [IDX_W-1:0]        idx_next_s;
    logic                    frame_wrap_s;
    logic [NUM_DIGITS-1:0]   zero_tail_s;
    logic [NUM_DIGITS-1:0]   blank_mask_s;
    logic [3:0]              nibble_s;
    logic                    dp_sel_s;
    logic                    blank_sel_s;
    glyph_t                  glyph_s;
    glyph_t                  seg_lit_s;
    logic [NUM_DIGITS-1:0]   an_lit_s;

    // Shadow registers capture a new display image only on the load strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_value_r <= {(4*NUM_DIGITS){1'b0}};
            shadow_dp_r    <= {NUM_DIGITS{1'b0}};
            shadow_blank_r <= 1'b0;
        end else if (load) begin
            shadow_value_r <= value;
            shadow_dp_r    <= dp_in;
            shadow_blank_r <= blank_lz;
        end else begin
            shadow_value_r <= shadow_value_r;
            shadow_dp_r    <= shadow_dp_r;
            shadow_blank_r <= shadow_blank_r;
        end
    end

    // Prescaler terminal count advances the scan index; a wrap marks a frame.
    always_comb begin
        presc_next_s = presc_r + PRESC_W'(1'b1);
        idx_next_s   = idx_r;
        frame_wrap_s = 1'b0;
        if (presc_r == PRESC_LAST) begin
            presc_next_s = {PRESC_W{1'b0}};
            if (idx_r == IDX_LAST) begin
                idx_next_s   = {IDX_W{1'b0}};
                frame_wrap_s = 1'b1;
            end else begin
                idx_next_s   = idx_r + IDX_W'(1'b1);
                frame_wrap_s = 1'b0;
            end
        end else begin
            idx_next_s   = idx_r;
            frame_wrap_s = 1'b0;
        end
    end

    // Scan state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_r <= {PRESC_W{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
        end else begin
            presc_r <= presc_next_s;
            idx_r   <= idx_next_s;
        end
    end

    // A digit is blanked when it and every more-significant nibble are zero.
    always_comb begin
        logic tail_zero;
        tail_zero    = 1'b1;
        zero_tail_s  = {NUM_DIGITS{1'b0}};
        blank_mask_s = {NUM_DIGITS{1'b0}};
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            tail_zero      = tail_zero & (shadow_value_r[4*k +: 4] == 4'h0);
            zero_tail_s[k] = tail_zero;
        end
        for (int k = 1; k < NUM_DIGITS; k++) begin
            blank_mask_s[k] = shadow_blank_r & zero_tail_s[k];
        end
    end

    // Select the active digit's nibble, decimal point and blanking decision.
    always_comb begin
        nibble_s    = shadow_value_r[{idx_r, 2'b00} +: 4];
        dp_sel_s    = shadow_dp_r[idx_r];
        blank_sel_s = blank_mask_s[idx_r];
        an_lit_s    = {NUM_DIGITS{1'b0}};
        an_lit_s[idx_r] = 1'b1;
    end

    hex_digit_decode u_decode (
        .nibble (nibble_s),
        .glyph  (glyph_s)
    );

    // Blanked digits keep their anode slot but drive no segments.
    always_comb begin
        if (blank_sel_s) begin
            seg_lit_s = SEG_BLANK;
        end else begin
            seg_lit_s = glyph_s;
        end
    end

    // Pin registers, refreshed every cycle from the current index and shadow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_r        <= SEG_OFF;
            dp_r         <= DP_OFF;
            an_r         <= AN_OFF;
            frame_tick_r <= 1'b0;
        end else begin
            seg_r        <= apply_polarity(seg_lit_s, SEG_ACTIVE_LOW);
            dp_r         <= dp_sel_s ^ DP_OFF;
            an_r         <= an_lit_s ^ AN_OFF;
            frame_tick_r <= frame_wrap_s;
        end
    end

    assign seg        = seg_r;
    assign dp         = dp_r;
    assign an         = an_r;
    assign frame_tick = frame_tick_r;

endmodule
